// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle ALU sequencer sharing one 64-bit ripple adder
module add_64 (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  output logic [63:0] sum_o,
  output logic        cout_o,
  output logic        of_o
);

  logic carry;

  // Ripple-carry chain, LSB first
  always_comb begin
    carry = 1'b0;
    sum_o = '0;
    for (int i = 0; i < 64; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

  assign of_o = (a_i[63] == b_i[63]) && (sum_o[63] != a_i[63]);

endmodule

module alu_seq_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NEG  = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout_unused;
  logic             add_of_unused;

  logic [WIDTH-1:0] exec_res;
  logic             exec_of;

  // Adder operand select, driven only by registered state so live inputs never reach it
  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      ST_NEG: begin
        add_a = ~b_q;
        add_b = {{(WIDTH-1){1'b0}}, 1'b1};
      end
      ST_EXEC: begin
        add_a = a_q;
        add_b = (op_q == OP_SUB) ? opnd_q : b_q;
      end
      default: begin
        add_a = '0;
        add_b = '0;
      end
    endcase
  end

  add_64 u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .sum_o  (add_sum),
    .cout_o (add_cout_unused),
    .of_o   (add_of_unused)
  );

  // EXEC-stage result and overflow; overflow uses the original operands so b = MIN still works
  always_comb begin
    exec_res = add_sum;
    exec_of  = 1'b0;
    case (op_q)
      OP_ADD: exec_of = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      OP_SUB: exec_of = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (add_sum[WIDTH-1] != a_q[WIDTH-1]);
      OP_AND: exec_res = a_q & b_q;
      OP_XOR: exec_res = a_q ^ b_q;
      default: begin
        exec_res = add_sum;
        exec_of  = 1'b0;
      end
    endcase
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          state_d = (in_op == OP_SUB) ? ST_NEG : ST_EXEC;
        end
      end
      ST_NEG: begin
        opnd_d  = add_sum;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = exec_res;
        zf_d    = (exec_res == '0);
        sf_d    = exec_res[WIDTH-1];
        of_d    = exec_of;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'd0;
      opnd_q  <= '0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_res   = res_q;
  assign out_zf    = zf_q;
  assign out_sf    = sf_q;
  assign out_of    = of_q;

endmodule
